// File: rtl/tt_scan_pkg.sv
// Shared types and constants for the truth-table scanner.
//   tt_state_t : scanner FSM states
//   AND_OR_TT  : golden table of the lab AND-OR cell (Y = ab | cd), index {a,b,c,d}
//   NVEC       : number of input vectors of a 4-input network
package tt_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } tt_state_t;

    localparam logic [15:0] AND_OR_TT = 16'hF888;
    localparam int          NVEC      = 16;

endpackage

// File: rtl/truth_table_scanner.sv
// Exhaustive tester for a 4-input combinational network. It steps through all
// 16 input vectors, lets each one settle, samples the device output and
// builds a truth table, which it compares against a golden table.
//
// Parameters:
//   SETTLE    settle cycles per vector before the sample cycle (1..15)
//   EXPECTED  golden truth table, bit index {a,b,c,d}
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      begin a scan (accepted only in IDLE)
//   busy       scan in progress
//   done       one-cycle pulse, results valid
//   a,b,c,d    registered vector driven to the device (a = MSB)
//   y          device output
//   tt         captured truth table
//   match      tt == EXPECTED, valid from done until the next start
//   err_count  number of mismatching vectors (0..16)
//   first_err  lowest mismatching index (0 when err_count == 0)
module truth_table_scanner
    import tt_scan_pkg::*;
#(
    parameter int unsigned SETTLE   = 2,
    parameter logic [15:0] EXPECTED = AND_OR_TT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    input  logic        y,
    output logic [15:0] tt,
    output logic        match,
    output logic [4:0]  err_count,
    output logic [3:0]  first_err
);

    localparam logic [3:0] CNT_RELOAD = 4'(SETTLE - 1);
    localparam logic [3:0] IDX_LAST   = 4'(NVEC - 1);

    tt_state_t   state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] tt_q, tt_d;
    logic [4:0]  err_q, err_d;
    logic [3:0]  ferr_q, ferr_d;
    logic        match_q, match_d;
    logic        done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            tt_q    <= '0;
            err_q   <= '0;
            ferr_q  <= '0;
            match_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            tt_q    <= tt_d;
            err_q   <= err_d;
            ferr_q  <= ferr_d;
            match_q <= match_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        tt_d    = tt_q;
        err_d   = err_q;
        ferr_d  = ferr_q;
        match_d = match_q;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    tt_d    = '0;
                    err_d   = '0;
                    ferr_d  = '0;
                    match_d = 1'b0;
                    idx_d   = '0;
                    cnt_d   = CNT_RELOAD;
                    state_d = ST_SETTLE;
                end
            end

            ST_SETTLE: begin
                if (cnt_q == 4'd0) state_d = ST_SAMPLE;
                else               cnt_d   = cnt_q - 4'd1;
            end

            ST_SAMPLE: begin
                tt_d[idx_q] = y;
                if (y != EXPECTED[idx_q]) begin
                    err_d = err_q + 5'd1;
                    if (err_q == 5'd0) ferr_d = idx_q;
                end
                if (idx_q == IDX_LAST) begin
                    // idx doubles as the vector register, so parking it at 0
                    // returns a..d to 0 for DONE/IDLE.
                    idx_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    cnt_d   = CNT_RELOAD;
                    state_d = ST_SETTLE;
                end
            end

            ST_DONE: begin
                // done and match are registered out of DONE so both are valid
                // in the same cycle; start in DONE is dropped, so the earliest
                // restart lands on the done cycle itself.
                match_d = (err_q == 5'd0);
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign busy         = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
    assign done         = done_q;
    assign {a, b, c, d} = idx_q;
    assign tt           = tt_q;
    assign match        = match_q;
    assign err_count    = err_q;
    assign first_err    = ferr_q;

endmodule

// File: doc/truth_table_scanner.md
# truth_table_scanner

Sequential exhaustive tester for 4-input combinational gate networks such as the lab's AND-OR cell. It drives all 16 input vectors onto the device's inputs in order, waits a programmable settle time, and samples the device's output. It assembles a 16-bit truth table, compares it against an expected table, and reports the result through a start/busy/done handshake. In the lab flow it sits between the stimulus controller and the gate-under-test; its outputs `a`..`d` connect to the device inputs and its `y` input connects to the device output.

## Interface
Parameters:
- `SETTLE`, default 2: settle cycles per vector before sampling. Legal range is 1..15.
- `EXPECTED`, default 16'hF888: golden truth table, bit index {a,b,c,d}. F888 is Y = ab | cd.

Ports:
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `start`, in, 1: begin a scan. Sampled only in IDLE.
- `busy`, out, 1: high from the cycle after `start` is accepted through the last SAMPLE.
- `done`, out, 1: one-cycle pulse when the result is valid.
- `a`, `b`, `c`, `d`, out, 1 each: current vector, registered. `a` is the MSB of the index.
- `y`, in, 1: device-under-test output.
- `tt`, out, 16: captured truth table. `tt[i]` is `y` for vector `i`.
- `match`, out, 1: `tt == EXPECTED`. Valid from the `done` cycle and held until the next start.
- `err_count`, out, 5: number of mismatching vectors, 0..16.
- `first_err`, out, 4: lowest mismatching index. It is 0 when `err_count` is 0.

## Operation
- States are IDLE, SETTLE, SAMPLE and DONE.
- **IDLE**:
  - `a`..`d` = 0 and `busy` = 0.
  - On `start` = 1: clear `tt`, `err_count`, `first_err` and `match`; set `idx` = 0; load the settle counter with SETTLE-1; go to SETTLE.
- **SETTLE**:
  - `a`..`d` = `idx`.
  - Decrement the counter.
  - When the counter = 0, go to SAMPLE.
- **SAMPLE**:
  - `a`..`d` are still `idx`.
  - At the closing edge, write `tt[idx]` = `y`.
  - If `y != EXPECTED[idx]`: increment `err_count`, and set `first_err` = `idx` if `err_count` was 0.
  - If `idx` = 15, go to DONE. Otherwise increment `idx`, reload the counter, and go to SETTLE.
- **DONE**:
  - `done` = 1 and `busy` = 0.
  - `match` is registered as (`err_count` == 0), which is equivalent to `tt == EXPECTED`.
  - Next state is IDLE unconditionally.
- Width rules:
  - `idx` is 4 bits and never wraps inside a scan; exit happens at 15.
  - `err_count` is 5 bits, so 16 is representable and no saturation logic is needed.
- `start` while busy or in DONE is ignored and not queued.
- `tt`, `err_count`, `first_err` and `match` hold after DONE until the next accepted start.
- Reset:
  - Reset values: state = IDLE; `busy`, `done`, `match`, `a`..`d` = 0; `tt` = 0; `err_count` = 0; `first_err` = 0.
  - Reset mid-scan aborts immediately. Partial results are discarded, and the next start begins a fresh scan from vector 0.
- `y` is treated as a combinational function of `a`..`d`. Only one sample is taken per vector.

## Timing
- `start` is accepted at edge T0.
- Vector `i` drives from the cycle after T0 + i·(SETTLE+1) and is held for SETTLE+1 cycles, with `y` sampled at the end of the last cycle.
- `done` is high in the cycle beginning at edge T0 + 16·(SETTLE+1) + 1. This is 49 cycles for SETTLE = 2.
- `busy` is high for exactly 16·(SETTLE+1) cycles.
- The earliest re-start is the cycle after DONE. This gives back-to-back scans with a 1-cycle IDLE gap.
- Vector outputs are registered, so there is no combinational path from `start` or `y` to any output.

## Structure
- Shared package `tt_scan_pkg` holds:
  - the state enum `tt_state_t` (IDLE, SETTLE, SAMPLE, DONE);
  - the localparam `AND_OR_TT` = 16'hF888;
  - `NVEC` = 16.
- Single module; no sub-module is required. The settle counter and `idx` stay inline.

## Test plan
- Golden AND-OR gate attached, SETTLE = 2, pulse `start` -> `done` at T0+49, `tt` = 16'hF888, `match` = 1, `err_count` = 0, `first_err` = 0.
- `y` tied to 0 -> `tt` = 0, `err_count` = 7, `first_err` = 3, `match` = 0.
- `y` = NOT(AND-OR) -> `tt` = 16'h0777, `err_count` = 16, `first_err` = 0.
- `start` re-pulsed at T0+10 and T0+49 -> ignored. Exactly one `done`, timing unchanged. Then `start` at T0+50 yields a second `done` at T0+99.
- Assert `rst_n` = 0 while vector 5 is driving -> all outputs return to reset values asynchronously. A new scan after release completes normally.
- SETTLE = 1 instance with the golden gate -> `done` at T0+33 and `match` = 1. Each vector is held exactly 2 cycles on `a`..`d`.
